// File: rtl/neuron_pkg.sv
// neuron_pkg: shared current format, FSM states and the saturating add.
// The state_update stage reuses sat_add, so the clamp rule is defined in one place.
package neuron_pkg;
    localparam int DATA_W = 17;
    localparam int FRAC_W = 8;
    typedef logic signed [DATA_W-1:0] current_t;
    localparam current_t CUR_MAX = 17'h0FFFF;
    localparam current_t CUR_MIN = 17'h10000;
    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
    typedef struct packed {
        current_t sum;
        logic     sat;
    } sat_res_t;
    function automatic sat_res_t sat_add(current_t a, current_t b);
        logic [DATA_W:0] s;
        sat_res_t r;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        r.sat = s[DATA_W] != s[DATA_W-1];
        r.sum = !r.sat ? current_t'(s[DATA_W-1:0]) : (s[DATA_W] ? CUR_MIN : CUR_MAX);
        return r;
    endfunction
endpackage

// File: rtl/synaptic_accumulator_if.sv
// synaptic_accumulator_if: spike-event input stream, step control and drained-current output stream.
interface synaptic_accumulator_if import neuron_pkg::*; #(
    parameter int ADDR_W = 4
);
    logic              ev_valid;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_dst;
    current_t          ev_weight;
    logic              step_start;
    current_t          bias_in;
    logic              i_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] i_idx;
    current_t          i_out;
    logic              step_done;
    logic              sat_flag;
    modport master (
        output ev_valid, ev_dst, ev_weight, step_start, bias_in, i_ready,
        input  ev_ready, i_valid, i_idx, i_out, step_done, sat_flag
    );
    modport slave (
        input  ev_valid, ev_dst, ev_weight, step_start, bias_in, i_ready,
        output ev_ready, i_valid, i_idx, i_out, step_done, sat_flag
    );
endinterface

// File: rtl/synaptic_accumulator_sat_adder.sv
// sat_adder: combinational two's-complement add clamped to the current range, with a clamp indicator.
module sat_adder import neuron_pkg::*; (
    input  current_t a,
    input  current_t b,
    output current_t sum,
    output logic     sat
);
    sat_res_t r;
    always_comb begin
        r   = sat_add(a, b);
        sum = r.sum;
        sat = r.sat;
    end
endmodule

// File: rtl/synaptic_accumulator.sv
// synaptic_accumulator: sums weighted spike events per neuron, then drains bias-added currents in index order.
// The drained word is formed from registered accumulator/bias state only, so no input reaches an output combinationally.
module synaptic_accumulator import neuron_pkg::*; #(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4
) (
    input logic                   clk,
    input logic                   reset,
    synaptic_accumulator_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    current_t          bias_q, bias_d;
    current_t          acc_q [N_NEURONS];
    current_t          acc_d [N_NEURONS];
    logic              i_valid_q, i_valid_d;
    logic              ev_ready_q, ev_ready_d;
    logic              step_done_q, step_done_d;
    logic              sat_q, sat_d;
    logic              dst_ok, ev_hs, xfer, acc_sat, out_sat;
    current_t          acc_cur, acc_sum, out_sum;

    assign dst_ok  = int'(bus.ev_dst) < N_NEURONS;
    assign ev_hs   = ev_ready_q && bus.ev_valid;
    assign xfer    = i_valid_q && bus.i_ready;
    assign acc_cur = dst_ok ? acc_q[bus.ev_dst] : '0;

    sat_adder u_acc_add (.a(acc_cur), .b(bus.ev_weight), .sum(acc_sum), .sat(acc_sat));
    sat_adder u_bias_add (.a(acc_q[idx_q]), .b(bias_q), .sum(out_sum), .sat(out_sat));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        sat_d   = sat_q || (ev_hs && dst_ok && acc_sat) || (i_valid_q && out_sat);
        if (ev_hs && dst_ok)
            acc_d[bus.ev_dst] = acc_sum;
        if (state_q == ACCUM && bus.step_start) begin
            state_d = DRAIN;
            idx_d   = '0;
            bias_d  = bus.bias_in;
        end
        // the last transfer leaves idx wrapped; it is re-zeroed at the next step_start
        if (xfer) begin
            acc_d[idx_q] = '0;
            idx_d        = idx_q + ADDR_W'(1);
            state_d      = idx_q == ADDR_W'(N_NEURONS - 1) ? DONE : DRAIN;
        end
        if (state_q == DONE)
            state_d = ACCUM;
        i_valid_d   = state_d == DRAIN;
        ev_ready_d  = state_d == ACCUM;
        step_done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            bias_q      <= '0;
            acc_q       <= '{default: '0};
            i_valid_q   <= 1'b0;
            ev_ready_q  <= 1'b1;
            step_done_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            i_valid_q   <= i_valid_d;
            ev_ready_q  <= ev_ready_d;
            step_done_q <= step_done_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.ev_ready  = ev_ready_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.i_idx     = i_valid_q ? idx_q : '0;
    assign bus.i_out     = i_valid_q ? out_sum : '0;
    assign bus.step_done = step_done_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_synaptic_accumulator.sv
// tb_synaptic_accumulator: directed events and steps; transfers are checked against a queue of hand-computed words.
module tb_synaptic_accumulator;
    import neuron_pkg::*;

    typedef struct {
        logic [3:0] idx;
        current_t   out;
    } xfer_t;

    localparam current_t W_ONE = current_t'(1) <<< FRAC_W;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    int       n_vec = 0;
    int       n_err = 0;
    xfer_t    exp_q[$];
    xfer_t    q12[$];
    current_t expv [16];
    logic     chk12 = 1'b0;
    logic     done12 = 1'b0;
    logic     held = 1'b0;
    logic [3:0] hold_idx;
    current_t hold_out;

    always #5 clk = ~clk;

    synaptic_accumulator_if #(.ADDR_W(4)) b();
    synaptic_accumulator_if #(.ADDR_W(4)) b12();

    synaptic_accumulator #(.N_NEURONS(16), .ADDR_W(4)) dut (.clk(clk), .reset(rst), .bus(b));
    synaptic_accumulator #(.N_NEURONS(12), .ADDR_W(4)) dut12 (.clk(clk), .reset(rst), .bus(b12));

    assign b12.ev_valid   = b.ev_valid;
    assign b12.ev_dst     = b.ev_dst;
    assign b12.ev_weight  = b.ev_weight;
    assign b12.step_start = b.step_start;
    assign b12.bias_in    = b.bias_in;
    assign b12.i_ready    = b.i_ready;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        xfer_t e;
        if (rst) held = 1'b0;
        else begin
            if (held) begin
                check("stall valid hold", b.i_valid, 1);
                check("stall idx hold", b.i_idx, hold_idx);
                check("stall out hold", b.i_out, hold_out);
            end
            if (b.i_valid) check("ev_ready low in drain", b.ev_ready, 0);
            if (b.i_valid && b.i_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra xfer: got idx %0d, expected none", b.i_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer idx", b.i_idx, e.idx);
                    check("xfer out", b.i_out, e.out);
                end
            end
            held = b.i_valid && !b.i_ready;
            hold_idx = b.i_idx;
            hold_out = b.i_out;
        end
    end

    always @(negedge clk) begin
        xfer_t e;
        if (!rst && chk12) begin
            if (b12.i_valid && b12.i_ready) begin
                if (q12.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL n12 extra xfer: got idx %0d, expected none", b12.i_idx);
                end else begin
                    e = q12.pop_front();
                    check("n12 xfer idx", b12.i_idx, e.idx);
                    check("n12 xfer out", b12.i_out, e.out);
                end
            end
            if (b12.step_done) done12 = 1'b1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_exp(input current_t v);
        foreach (expv[i]) expv[i] = v;
    endtask

    task automatic send(input logic [3:0] dst, input current_t w);
        b.ev_valid  = 1'b1;
        b.ev_dst    = dst;
        b.ev_weight = w;
        @(posedge clk); #1;
        b.ev_valid  = 1'b0;
    endtask

    task automatic do_step(input current_t bias, input bit stall, input bit poke, input bit same_ev);
        xfer_t x;
        logic [3:0] pat = 4'b1001;
        int cyc = 0;
        int done_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            x.idx = 4'(i);
            x.out = expv[i];
            exp_q.push_back(x);
            if (chk12 && i < 12) q12.push_back(x);
        end
        b.step_start = 1'b1;
        b.bias_in    = bias;
        if (same_ev) begin
            b.ev_valid  = 1'b1;
            b.ev_dst    = 4'd2;
            b.ev_weight = 17'h00400;
        end
        @(posedge clk); #1;
        b.step_start = 1'b0;
        b.ev_valid   = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            b.i_ready = stall ? pat[3 - (cyc % 4)] : 1'b1;
            if (poke) begin
                b.ev_valid   = 1'b1;
                b.ev_dst     = 4'd0;
                b.ev_weight  = 17'h00100;
                b.step_start = cyc == 5;
            end
            @(negedge clk);
            if (b.step_done) done_cyc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        b.ev_valid   = 1'b0;
        b.step_start = 1'b0;
        b.i_ready    = 1'b1;
        check("step_done seen", done_cyc >= 0, 1);
        if (!stall) check("step latency", done_cyc, 16);
        check("scoreboard empty", exp_q.size(), 0);
        @(negedge clk);
        check("step_done one cycle", b.step_done, 0);
        check("ev_ready after step", b.ev_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit found;
        b.ev_valid = 1'b0; b.ev_dst = '0; b.ev_weight = '0;
        b.step_start = 1'b0; b.bias_in = '0; b.i_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("reset ev_ready", b.ev_ready, 1);
        check("reset i_valid", b.i_valid, 0);
        check("reset i_idx", b.i_idx, 0);
        check("reset i_out", b.i_out, 0);
        check("reset step_done", b.step_done, 0);
        check("reset sat_flag", b.sat_flag, 0);
        @(posedge clk); #1;

        set_exp('0);
        do_step('0, 0, 0, 0);

        send(3, 17'h00600); send(3, 17'h00200); send(3, 17'h1FF00);
        set_exp(17'h00100); expv[3] = 17'h00800;
        do_step(W_ONE, 0, 0, 0);
        check("no sat after accumulate", b.sat_flag, 0);

        repeat (8) send(5, 17'h07000);
        set_exp('0); expv[5] = 17'h0FFFF;
        do_step('0, 0, 0, 0);
        check("sat_flag high clamp", b.sat_flag, 1);

        do_reset();
        repeat (8) send(6, 17'h19000);
        set_exp('0); expv[6] = 17'h10000;
        do_step('0, 0, 0, 0);
        check("sat_flag low clamp", b.sat_flag, 1);

        send(4, 17'h00300);
        set_exp('0); expv[4] = 17'h00300;
        do_step('0, 1, 1, 0);
        set_exp('0);
        do_step('0, 0, 0, 0);

        send(15, 17'h00200);
        set_exp(17'h00080); expv[2] = 17'h00480; expv[15] = 17'h00280;
        do_step(17'h00080, 0, 0, 1);
        set_exp(17'h00080);
        do_step(17'h00080, 0, 0, 0);

        send(7, 17'h00100); send(9, 17'h00300);
        for (int i = 0; i < 8; i++) begin
            xfer_t x;
            x.idx = 4'(i);
            x.out = i == 7 ? 17'h00100 : 17'h00000;
            exp_q.push_back(x);
        end
        b.step_start = 1'b1; b.bias_in = '0;
        @(posedge clk); #1;
        b.step_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (b.i_valid && b.i_idx == 4'd7) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reached idx 7", found, 1);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("scoreboard empty at abort", exp_q.size(), 0);
        @(negedge clk);
        check("abort no step_done", b.step_done, 0);
        check("abort i_valid", b.i_valid, 0);
        check("abort ev_ready", b.ev_ready, 1);
        @(posedge clk); #1;
        set_exp('0);
        do_step('0, 0, 0, 0);

        do_reset();
        chk12 = 1'b1;
        send(13, 17'h00500); send(11, 17'h00200);
        set_exp('0); expv[11] = 17'h00200; expv[13] = 17'h00500;
        do_step('0, 0, 0, 0);
        check("n12 step_done seen", done12, 1);
        check("n12 scoreboard empty", q12.size(), 0);
        check("n12 sat_flag", b12.sat_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule

// File: doc/synaptic_accumulator.md
Name: synaptic_accumulator

Overview:
Upstream feeder for state_update. Collects weighted spike events addressed to each neuron during a timestep and holds them in per-neuron current accumulators. On a step boundary it drains one saturated input current per neuron, in index order, to the neuron update stage over a valid/ready stream. Each accumulator is cleared once its value has been handed off.

Parameters:
N_NEURONS, 16, number of neurons and accumulators
ADDR_W, 4, neuron index width; must satisfy 2**ADDR_W >= N_NEURONS
DATA_W, 17, current word width; two's complement, 8 fractional bits (17'h00600 = +6.0)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ev_valid  in  1  spike event offered
ev_ready  out  1  event accepted when ev_valid && ev_ready
ev_dst  in  ADDR_W  destination neuron index
ev_weight  in  DATA_W  signed synaptic weight
step_start  in  1  one-cycle pulse that ends accumulation and starts the drain
bias_in  in  DATA_W  signed external current added to every neuron; sampled on step_start
i_valid  out  1  i_out and i_idx are valid
i_ready  in  1  downstream accepts; transfer when i_valid && i_ready
i_idx  out  ADDR_W  neuron index of i_out
i_out  out  DATA_W  input current for the neuron update stage (drives state_update i_in)
step_done  out  1  one-cycle pulse after the last neuron transfers
sat_flag  out  1  sticky; set on any saturation event; cleared only by reset

Behaviour:
- Reset values: all accumulators 0, state ACCUM, ev_ready=1, i_valid=0, i_idx=0, i_out=0, step_done=0, sat_flag=0. Reset asserted mid-drain abandons the drain: no step_done, accumulators zeroed.
- Saturating add: sat(a+b) is computed at DATA_W+1 bits and clamps to [17'h10000 (-256.0), 17'h0FFFF (+255.996)]. Any clamp sets sat_flag.
- State ACCUM:
  - ev_ready=1.
  - On an event handshake, acc[ev_dst] <= sat(acc[ev_dst]+ev_weight), written at the next edge. Back-to-back events to the same neuron every cycle must all be summed; the RTL needs no bypass because the write completes each cycle.
  - ev_dst >= N_NEURONS: the event is accepted and discarded, with no state change.
  - step_start: latch bias into bias_q, set idx=0, go to DRAIN. An event handshaken in the same cycle as step_start is included in the drained sum.
- State DRAIN:
  - ev_ready=0; ev_valid is ignored.
  - i_valid is asserted 1 cycle after step_start, with i_idx=0 and i_out=sat(acc[0]+bias_q).
  - While i_valid && !i_ready, i_idx and i_out are held stable.
  - On a transfer, acc[idx] <= 0 and idx increments. The next word is presented in the following cycle, so with i_ready held high there is one transfer per cycle and no bubbles.
  - The transfer with idx == N_NEURONS-1 moves the block to DONE with i_valid=0.
  - step_start during DRAIN or DONE is ignored.
- State DONE: step_done=1 for exactly one cycle, then back to ACCUM with ev_ready=1.
- Step latency with no stalls: step_start to step_done = N_NEURONS+1 cycles.
- Outputs are registered. There is no combinational path from ev_* or i_ready to any output; ev_ready is a registered state decode.

Decomposition:
- Shared package neuron_pkg holds:
  - DATA_W and FRAC_W=8
  - the current_t typedef
  - CUR_MAX=17'h0FFFF and CUR_MIN=17'h10000
  - the state enum {ACCUM, DRAIN, DONE}
  - the sat_add function, which state_update will reuse.
- One natural sub-module, sat_adder. It is combinational: a, b in; sum and sat out. It is instanced twice: once for the accumulate path and once for the bias-add path.

Test Plan:
- Reset then idle: reset 1 cycle -> ev_ready=1, i_valid=0, sat_flag=0. With step_start, bias=0, i_ready=1, expect 16 transfers (i_idx 0..15, i_out all 0), step_done exactly 1 cycle after the last transfer.
- Accumulate: weights 17'h00600, 17'h00200, 17'h1FF00 (-1.0) sent to neuron 3, then step_start with bias 17'h00100 -> i_idx=3 gives i_out=17'h00800 (+8.0); all other indices give 17'h00100.
- Saturation: eight events of 17'h07000 to neuron 5 -> i_out for idx 5 = 17'h0FFFF and sat_flag=1. The same test with 17'h19000 sent to neuron 6 -> 17'h10000.
- Backpressure: i_ready toggles 1,0,0,1 during the drain -> i_idx and i_out are held while stalled; no index is skipped or duplicated; ev_ready=0 throughout the drain.
- Clear and boundary: 17'h00400 to neuron 2 in the same cycle as step_start -> included in the drain. A second step with no events -> idx 2 reads bias only. ev_dst=15 (valid index) is accumulated; a run with N_NEURONS=12 and ev_dst=13 shows the event dropped.
- Reset mid-drain: reset asserted with i_idx=7 -> no step_done, state returns to ACCUM. The next step drains all zeros.
